mem_arbiter: RTL and testbench

Two-master arbiter that lets the core's instruction-fetch port and data port share the single native memory bus (`mem_valid`/`mem_ready` handshake). It sits between the core and the memory/testbench port. It grants one requester at a time using round-robin on contention and holds the grant until the memory completes. A watchdog counter aborts hung transactions with an error pulse, so a stalled bus never deadlocks the core.

---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one native memory bus between the instruction-fetch and data ports.
// A watchdog aborts a BUSY transaction that never sees mem_ready and reports it as an error pulse.
module mem_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic        i_err,
    output logic [31:0] i_rdata,
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ready,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam bit            WD_EN   = (TIMEOUT != 0);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state_reg;
    logic          last_reg;   // most recently granted port: 0 = instr, 1 = data
    logic          gnt_reg;    // port owning the current transaction
    logic [CW-1:0] wd_reg;
    logic          pick_data;
    logic          done_ok;
    logic          done_err;

    // On a tie the port that did not win last time gets the bus.
    always_comb begin
        pick_data = d_valid;
        if (i_valid && d_valid) begin
            pick_data = ~last_reg;
        end
    end

    // mem_ready takes priority over a watchdog expiry in the same cycle.
    assign done_ok  = (state_reg == ST_BUSY) && mem_ready;
    assign done_err = (state_reg == ST_BUSY) && !mem_ready && WD_EN && (wd_reg == WD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            last_reg  <= 1'b1;
            gnt_reg   <= 1'b0;
            wd_reg    <= '0;
            mem_valid <= 1'b0;
            mem_instr <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_valid || d_valid) begin
                        gnt_reg   <= pick_data;
                        last_reg  <= pick_data;
                        wd_reg    <= '0;
                        mem_valid <= 1'b1;
                        mem_instr <= ~pick_data;
                        if (pick_data) begin
                            mem_addr  <= d_addr;
                            mem_wstrb <= d_wstrb;
                            mem_wdata <= (d_wstrb == 4'b0000) ? 32'h0 : d_wdata;
                        end else begin
                            mem_addr  <= i_addr;
                            mem_wstrb <= 4'b0000;
                            mem_wdata <= 32'h0;
                        end
                        state_reg <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (done_ok || done_err) begin
                        mem_valid <= 1'b0;
                        state_reg <= ST_RESP;
                    end else begin
                        wd_reg <= wd_reg + 1'b1;
                    end
                end
                ST_RESP: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Per-port response registers: index 0 = instr, 1 = data.
    logic [1:0]  ready_reg;
    logic [1:0]  err_reg;
    logic [31:0] rdata_reg [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            logic sel;
            assign sel = (gnt_reg == gi[0]);

            always_ff @(posedge clk) begin
                if (reset) begin
                    ready_reg[gi] <= 1'b0;
                    err_reg[gi]   <= 1'b0;
                    rdata_reg[gi] <= '0;
                end else begin
                    ready_reg[gi] <= done_ok && sel;
                    err_reg[gi]   <= done_err && sel;
                    if (done_ok && sel) begin
                        rdata_reg[gi] <= mem_rdata;
                    end else if (done_err && sel) begin
                        rdata_reg[gi] <= '0;
                    end
                end
            end
        end
    endgenerate

    assign i_ready = ready_reg[0];
    assign i_err   = err_reg[0];
    assign i_rdata = rdata_reg[0];
    assign d_ready = ready_reg[1];
    assign d_err   = err_reg[1];
    assign d_rdata = rdata_reg[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single fetch, store, contention, timeout, collision, reset in BUSY.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic [31:0] i_addr;
    logic        i_ready, i_err;
    logic [31:0] i_rdata;
    logic        d_valid;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ready, d_err;
    logic [31:0] d_rdata;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(4), .CW(8)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_err(i_err), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ready(d_ready), .d_err(d_err), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int i_cnt;
        int d_cnt;
        int hi;
        logic exp_i;

        reset = 1'b1; i_valid = 0; i_addr = 0; d_valid = 0; d_addr = 0;
        d_wdata = 0; d_wstrb = 0; mem_ready = 0; mem_rdata = 0;
        tick(); tick();
        check("rst mem_valid", {31'b0, mem_valid}, 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst i_ready", {31'b0, i_ready}, 32'd0);
        check("rst d_err", {31'b0, d_err}, 32'd0);
        check("rst i_rdata", i_rdata, 32'd0);
        reset = 1'b0;
        tick();

        // Single fetch with zero-wait memory
        i_valid = 1; i_addr = 32'h100;
        tick();
        check("fetch mem_valid", {31'b0, mem_valid}, 32'd1);
        check("fetch mem_instr", {31'b0, mem_instr}, 32'd1);
        check("fetch mem_addr", mem_addr, 32'h100);
        check("fetch mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
        mem_ready = 1; mem_rdata = 32'h13;
        tick();
        check("fetch i_ready", {31'b0, i_ready}, 32'd1);
        check("fetch i_rdata", i_rdata, 32'h13);
        check("fetch d_ready", {31'b0, d_ready}, 32'd0);
        check("fetch mem_valid drop", {31'b0, mem_valid}, 32'd0);
        mem_ready = 0; i_valid = 0;
        tick();
        check("fetch i_ready clear", {31'b0, i_ready}, 32'd0);

        // Data store
        d_valid = 1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
        tick();
        check("store mem_instr", {31'b0, mem_instr}, 32'd0);
        check("store mem_addr", mem_addr, 32'h2004);
        check("store mem_wdata", mem_wdata, 32'hDEADBEEF);
        check("store mem_wstrb", {28'b0, mem_wstrb}, 32'h3);
        mem_ready = 1; mem_rdata = 32'h0;
        tick();
        check("store d_ready", {31'b0, d_ready}, 32'd1);
        check("store i_ready", {31'b0, i_ready}, 32'd0);
        mem_ready = 0; d_valid = 0; d_wstrb = 0;
        tick();
        check("store d_ready clear", {31'b0, d_ready}, 32'd0);

        // Contention from reset: order I, D, I, D
        reset = 1; tick(); reset = 0;
        i_valid = 1; i_addr = 32'h1000; d_valid = 1; d_addr = 32'h2000; d_wstrb = 0;
        i_cnt = 0; d_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            exp_i = (k % 2 == 0);
            tick();
            check($sformatf("cont%0d mem_instr", k), {31'b0, mem_instr}, {31'b0, exp_i});
            check($sformatf("cont%0d mem_addr", k), mem_addr, exp_i ? 32'h1000 : 32'h2000);
            mem_ready = 1; mem_rdata = 32'hA000_0000 + k;
            tick();
            mem_ready = 0;
            if (i_ready) i_cnt++;
            if (d_ready) d_cnt++;
            check($sformatf("cont%0d rdata", k), exp_i ? i_rdata : d_rdata, 32'hA000_0000 + k);
            check($sformatf("cont%0d other ready", k), {31'b0, exp_i ? d_ready : i_ready}, 32'd0);
            tick();
        end
        check("cont i pulses", i_cnt, 32'd2);
        check("cont d pulses", d_cnt, 32'd2);
        i_valid = 0; d_valid = 0;
        tick();

        // Timeout on a data read
        d_valid = 1; d_addr = 32'h3000; d_wstrb = 0;
        tick();
        hi = 0;
        while (mem_valid && hi < 20) begin
            hi++;
            tick();
        end
        check("tmo mem_valid cycles", hi, 32'd4);
        check("tmo d_err", {31'b0, d_err}, 32'd1);
        check("tmo d_rdata", d_rdata, 32'd0);
        check("tmo d_ready", {31'b0, d_ready}, 32'd0);
        d_valid = 0;
        tick();
        check("tmo d_err clear", {31'b0, d_err}, 32'd0);
        i_valid = 1; i_addr = 32'h200;
        tick();
        check("post-tmo mem_instr", {31'b0, mem_instr}, 32'd1);
        mem_ready = 1; mem_rdata = 32'h55;
        tick();
        check("post-tmo i_ready", {31'b0, i_ready}, 32'd1);
        check("post-tmo i_rdata", i_rdata, 32'h55);
        mem_ready = 0; i_valid = 0;
        tick();

        // mem_ready in the 4th BUSY cycle beats the watchdog
        d_valid = 1; d_addr = 32'h3100;
        tick(); tick(); tick(); tick();
        check("coll mem_valid", {31'b0, mem_valid}, 32'd1);
        mem_ready = 1; mem_rdata = 32'h77;
        tick();
        check("coll d_ready", {31'b0, d_ready}, 32'd1);
        check("coll d_err", {31'b0, d_err}, 32'd0);
        check("coll d_rdata", d_rdata, 32'h77);
        mem_ready = 0; d_valid = 0;
        tick();

        // Reset in BUSY after an instr grant
        i_valid = 1; i_addr = 32'h400;
        tick();
        reset = 1; mem_ready = 1; mem_rdata = 32'h99;
        tick();
        check("rstbusy mem_valid", {31'b0, mem_valid}, 32'd0);
        check("rstbusy i_ready", {31'b0, i_ready}, 32'd0);
        check("rstbusy i_err", {31'b0, i_err}, 32'd0);
        reset = 0; mem_ready = 0; d_valid = 1; d_addr = 32'h500;
        tick();
        check("rstbusy tie mem_instr", {31'b0, mem_instr}, 32'd1);
        check("rstbusy tie mem_addr", mem_addr, 32'h400);
        mem_ready = 1; mem_rdata = 32'h12;
        tick();
        check("rstbusy i_ready", {31'b0, i_ready}, 32'd1);
        mem_ready = 0; i_valid = 0; d_valid = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
